car_motion_ctrl: RTL and testbench
==================================

// Module: car_motion_ctrl
// PURPOSE
// - Parametrised elevator car motion controller: accepts one target-floor request at a time via valid/ready,
//   steps the car one floor per FTOF_TIME cycles, pulses arr on arrival, then runs a timed door-open phase.
// - Sits between the request scheduler (upstream, issues req_floor) and the floor display/door drivers (downstream).
// PARAMETERS
// - N_FLOORS   8    number of floors; valid floors are 1..N_FLOORS
// - FLOOR_W    4    width of floor buses; must satisfy 2**FLOOR_W > N_FLOORS
// - FTOF_TIME  50   cycles to travel one floor (>=2)
// - DOOR_TIME  100  cycles the door stays open after arrival (>=1)
// - HOME_FLOOR 1    floor loaded into now_floor at reset
// PORTS
// - clk        in   1        system clock, all logic on posedge
// - rst_n      in   1        asynchronous active-low reset
// - req_valid  in   1        target-floor request valid
// - req_floor  in   FLOOR_W  target floor
// - req_ready  out  1        controller can accept a request (high only in IDLE)
// - req_err    out  1        1-cycle pulse: accepted request was out of range, discarded
// - now_floor  out  FLOOR_W  current floor
// - moving     out  1        car is travelling between floors
// - dir_up     out  1        travel direction; 1=up, 0=down; holds last value when stopped
// - arr        out  1        1-cycle pulse on arrival at the target floor
// - door_open  out  1        door open indication
// - estop      in   1        emergency stop (present only with CAR_ESTOP_EN)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, now_floor=HOME_FLOOR, cnt=0, req_ready=1, req_err=0, moving=0,
//   dir_up=1, arr=0, door_open=0. Reset mid-travel or mid-door abandons the operation immediately.
// - All outputs registered. Handshake: request accepted in a cycle with req_valid && req_ready; req_floor is
//   captured into tgt that cycle; req_ready drops the following cycle and stays low until return to IDLE.
// - States: IDLE, MOVE, ARRIVE, DOOR.
//   IDLE -> (accept, req_floor==0 or >N_FLOORS): stay IDLE, req_err=1 for one cycle.
//   IDLE -> (accept, req_floor==now_floor): ARRIVE (no travel).
//   IDLE -> (accept, otherwise): MOVE; dir_up=(req_floor>now_floor); moving=1; cnt=0.
//   MOVE: cnt increments each cycle; when cnt==FTOF_TIME-1: now_floor +/-1 per dir_up, cnt=0; if the new
//   floor equals tgt -> ARRIVE. Exactly FTOF_TIME cycles per floor; floor never passes 1 or N_FLOORS.
//   ARRIVE (1 cycle): arr=1, moving=0, door_open=1, cnt=0 -> DOOR.
//   DOOR: door_open=1; cnt counts to DOOR_TIME-1 then door_open=0, -> IDLE (req_ready=1 next cycle).
// - Latency: accept at cycle T to arr pulse = 1 + |tgt-now|*FTOF_TIME cycles; same-floor request: arr at T+1.
// - req_valid while req_ready=0 is ignored (not queued); upstream holds it until accepted.
// - cnt width $clog2(max(FTOF_TIME,DOOR_TIME)); floor arithmetic unsigned FLOOR_W, no wrap possible by range check.
// CONFIGURATION
// - CAR_ESTOP_EN defined: estop port exists. In MOVE, estop=1 freezes cnt and now_floor, moving=0;
//   on estop=0 travel resumes from the frozen cnt. In DOOR, estop=1 freezes the door timer (door stays open).
//   In IDLE, estop=1 forces req_ready=0. ARRIVE is unaffected.
// - CAR_ESTOP_EN undefined: no estop port; behaviour as if estop=0.
// STRUCTURE
// - Package car_pkg: state enum (IDLE, MOVE, ARRIVE, DOOR), FLOOR_W-based floor typedef, default timing constants.
// - One sub-module car_tick_timer: loadable up-counter with enable/clear and terminal-count output,
//   shared for floor travel (FTOF_TIME) and door timing (DOOR_TIME); FSM and floor register stay in top.
// TESTING
// - Reset, then req_floor=4 from floor 1 (FTOF_TIME=50): now_floor 2,3,4 at +51,+101,+151; arr at cycle +151.
// - At floor 4 req_floor=2: dir_up=0, moving=1, arr after 101 cycles; door_open high exactly DOOR_TIME+1 cycles.
// - req_floor=now_floor: arr next cycle, no change in now_floor, moving stays 0.
// - req_floor=0 and req_floor=9 (N_FLOORS=8): req_err pulse, state stays IDLE, now_floor unchanged.
// - rst_n low mid-travel at floor 3 toward 6: outputs return to reset values asynchronously; new request works.
// - CAR_ESTOP_EN: estop high 30 cycles mid-floor -> arrival delayed exactly 30 cycles; estop in DOOR extends door.

Source files
------------

// File: rtl/car_pkg.sv
// ----------------------------------------------------------------------------
// car_pkg
// Shared types and defaults for the elevator car motion controller.
//   car_state_t : controller states (IDLE, MOVE, ARRIVE, DOOR)
//   floor_t     : floor bus at the default FLOOR_W width
//   *_DEF       : default geometry/timing used as parameter defaults
//   cnt_width() : width of the shared tick counter for two timing constants
// ----------------------------------------------------------------------------
package car_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        ARRIVE = 2'd2,
        DOOR   = 2'd3
    } car_state_t;

    localparam int FLOOR_W_DEF    = 4;
    localparam int N_FLOORS_DEF   = 8;
    localparam int FTOF_TIME_DEF  = 50;
    localparam int DOOR_TIME_DEF  = 100;
    localparam int HOME_FLOOR_DEF = 1;

    typedef logic [FLOOR_W_DEF-1:0] floor_t;

    // Counter width able to hold 0 .. max(a,b)-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/car_tick_timer.sv
// ----------------------------------------------------------------------------
// car_tick_timer
// Up-counter with synchronous clear, count enable and a terminal value that
// is supplied (loaded) by the caller each cycle. On an enabled cycle at the
// terminal value the counter wraps to zero. Used for both the floor-to-floor
// travel time and the door-open time.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to zero (priority over en)
//   en         : advance the count
//   term       : terminal value (period - 1)
//   tc         : count currently equals term
// ----------------------------------------------------------------------------
module car_tick_timer
    import car_pkg::*;
#(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/car_motion_ctrl.sv
// ----------------------------------------------------------------------------
// car_motion_ctrl
// Elevator car motion controller. Accepts one target floor at a time over a
// valid/ready handshake, steps the car one floor every FTOF_TIME cycles,
// pulses arr on arrival and then holds the door open for DOOR_TIME cycles.
// Optional feature macro: CAR_ESTOP_EN adds the estop input, which freezes
// travel and the door timer and blocks new requests while asserted.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_floor   : target-floor request
//   req_ready             : request can be accepted (IDLE only)
//   req_err               : 1-cycle pulse, accepted request out of range
//   now_floor             : current floor
//   moving, dir_up        : travelling flag, direction (held when stopped)
//   arr                   : 1-cycle pulse on arrival
//   door_open             : door open indication
//   estop                 : emergency stop (CAR_ESTOP_EN only)
// All outputs are registered.
// ----------------------------------------------------------------------------
module car_motion_ctrl
    import car_pkg::*;
#(
    parameter int N_FLOORS   = N_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF,
    parameter int FTOF_TIME  = FTOF_TIME_DEF,
    parameter int DOOR_TIME  = DOOR_TIME_DEF,
    parameter int HOME_FLOOR = HOME_FLOOR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic               req_ready,
    output logic               req_err,
    output logic [FLOOR_W-1:0] now_floor,
    output logic               moving,
    output logic               dir_up,
    output logic               arr,
    output logic               door_open
`ifdef CAR_ESTOP_EN
    ,
    input  logic               estop
`endif
);

    localparam int               CNT_W     = cnt_width(FTOF_TIME, DOOR_TIME);
    localparam logic [CNT_W-1:0] FTOF_TERM = CNT_W'(FTOF_TIME - 1);
    localparam logic [CNT_W-1:0] DOOR_TERM = CNT_W'(DOOR_TIME - 1);

    car_state_t         state, state_nx;
    logic [FLOOR_W-1:0] tgt, tgt_nx, floor_nx, step_floor;
    logic               ready_nx, err_nx, moving_nx, dir_nx, arr_nx, door_nx;
    logic               tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0]   tmr_term;
    logic               halt, accept, req_bad, req_here, last_tick, floor_done;

`ifdef CAR_ESTOP_EN
    assign halt = estop;
`else
    assign halt = 1'b0;
`endif

    assign accept     = req_valid && req_ready;
    assign req_bad    = (req_floor == '0) || (req_floor > FLOOR_W'(N_FLOORS));
    assign req_here   = (req_floor == now_floor);
    assign step_floor = dir_up ? now_floor + 1'b1 : now_floor - 1'b1;
    // A frozen timer never completes a period.
    assign last_tick  = tmr_tc && !halt;
    assign floor_done = last_tick && (step_floor == tgt);
    assign tmr_term   = (state == DOOR) ? DOOR_TERM : FTOF_TERM;

    car_tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .term  (tmr_term),
        .tc    (tmr_tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && !req_bad) state_nx = req_here ? ARRIVE : MOVE;
            end
            MOVE:    if (floor_done) state_nx = ARRIVE;
            ARRIVE:  state_nx = DOOR;
            DOOR:    if (last_tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and timer control
    always_comb begin
        floor_nx  = now_floor;
        tgt_nx    = tgt;
        dir_nx    = dir_up;
        moving_nx = 1'b0;
        ready_nx  = 1'b0;
        err_nx    = 1'b0;
        arr_nx    = 1'b0;
        door_nx   = 1'b0;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        unique case (state)
            IDLE: begin
                ready_nx = !halt;
                if (accept) begin
                    tgt_nx = req_floor;
                    if (req_bad) begin
                        err_nx = 1'b1;
                    end else if (req_here) begin
                        ready_nx = 1'b0;
                        arr_nx   = 1'b1;
                        door_nx  = 1'b1;
                    end else begin
                        ready_nx  = 1'b0;
                        dir_nx    = (req_floor > now_floor);
                        moving_nx = 1'b1;
                        tmr_clr   = 1'b1;
                    end
                end
            end
            MOVE: begin
                tmr_en    = !halt;
                moving_nx = !halt;
                if (last_tick) begin
                    floor_nx = step_floor;
                    if (floor_done) begin
                        moving_nx = 1'b0;
                        arr_nx    = 1'b1;
                        door_nx   = 1'b1;
                    end
                end
            end
            ARRIVE: begin
                door_nx = 1'b1;
                tmr_clr = 1'b1;
            end
            DOOR: begin
                tmr_en   = !halt;
                door_nx  = !last_tick;
                ready_nx = last_tick;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_floor <= FLOOR_W'(HOME_FLOOR);
            tgt       <= FLOOR_W'(HOME_FLOOR);
            req_ready <= 1'b1;
            req_err   <= 1'b0;
            moving    <= 1'b0;
            dir_up    <= 1'b1;
            arr       <= 1'b0;
            door_open <= 1'b0;
        end else begin
            now_floor <= floor_nx;
            tgt       <= tgt_nx;
            req_ready <= ready_nx;
            req_err   <= err_nx;
            moving    <= moving_nx;
            dir_up    <= dir_nx;
            arr       <= arr_nx;
            door_open <= door_nx;
        end
    end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// ----------------------------------------------------------------------------
// tb_car_motion_ctrl
// Scoreboard bench for car_motion_ctrl at default parameters. Each request
// pushes the events it should cause (floor steps, arrival, error pulse,
// door close) with their expected cycle; a negedge monitor pops and compares
// them as the DUT produces them. Estop scenarios run under CAR_ESTOP_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_car_motion_ctrl;
    import car_pkg::*;

    localparam int N_FLOORS = 8;
    localparam int FLOOR_W  = 4;
    localparam int FTOF     = 50;
    localparam int DOOR     = 100;
    localparam int HOME     = 1;

    localparam int EV_STEP = 0;
    localparam int EV_ARR  = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_DOOR = 3;

    typedef struct {
        int kind;
        int val;
        int cyc;
        int aux;
    } ev_t;

    logic   clk       = 1'b0;
    logic   rst_n     = 1'b0;
    logic   req_valid = 1'b0;
    floor_t req_floor = '0;
    logic   req_ready, req_err, moving, dir_up, arr, door_open;
    floor_t now_floor;
`ifdef CAR_ESTOP_EN
    logic   estop = 1'b0;
`endif

    ev_t  sb[$];
    int   n_chk       = 0;
    int   n_err       = 0;
    int   cyc         = 0;
    int   model_floor = HOME;
    int   model_dir   = 1;
    int   prev_floor  = HOME;
    logic door_prev   = 1'b0;

    car_motion_ctrl #(
        .N_FLOORS   (N_FLOORS),
        .FLOOR_W    (FLOOR_W),
        .FTOF_TIME  (FTOF),
        .DOOR_TIME  (DOOR),
        .HOME_FLOOR (HOME)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_floor (req_floor),
        .req_ready (req_ready),
        .req_err   (req_err),
        .now_floor (now_floor),
        .moving    (moving),
        .dir_up    (dir_up),
        .arr       (arr),
        .door_open (door_open)
`ifdef CAR_ESTOP_EN
        ,
        .estop     (estop)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int v, input int c, input int a);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.cyc  = c;
        e.aux  = a;
        sb.push_back(e);
    endtask

    task automatic match(input int k, input int v, input int a);
        ev_t e;
        if (sb.size() == 0) begin
            chk($sformatf("unexpected_ev%0d", k), sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("ev%0d_kind", e.kind), k, e.kind);
        chk($sformatf("ev%0d_floor", e.kind), v, e.val);
        chk($sformatf("ev%0d_cycle", e.kind), cyc, e.cyc);
        chk($sformatf("ev%0d_aux", e.kind), a, e.aux);
    endtask

    // Monitor: aux is moving for steps, dir_up for arrivals, req_ready otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_floor = int'(now_floor);
            door_prev  = 1'b0;
        end else begin
            if (int'(now_floor) != prev_floor) match(EV_STEP, int'(now_floor), int'(moving));
            if (arr)                           match(EV_ARR,  int'(now_floor), int'(dir_up));
            if (req_err)                       match(EV_ERR,  int'(now_floor), int'(req_ready));
            if (door_prev && !door_open)       match(EV_DOOR, int'(now_floor), int'(req_ready));
            prev_floor = int'(now_floor);
            door_prev  = door_open;
        end
    end

    task automatic send_req(input int f, input int hold_mv, input int hold_door);
        int n;
        int a;
        int d;
        int arr_c;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", req_ready, 1);
        req_valid = 1'b1;
        req_floor = f[FLOOR_W-1:0];
        @(posedge clk);
        #1;
        a         = cyc;
        req_valid = 1'b0;
        if (f == 0 || f > N_FLOORS) begin
            push(EV_ERR, model_floor, a, 1);
        end else if (f == model_floor) begin
            push(EV_ARR, f, a, model_dir);
            push(EV_DOOR, f, a + DOOR + 1 + hold_door, 1);
        end else begin
            model_dir = (f > model_floor) ? 1 : 0;
            d = (f > model_floor) ? f - model_floor : model_floor - f;
            for (int k = 1; k <= d; k++)
                push(EV_STEP, model_dir ? model_floor + k : model_floor - k,
                     a + k * FTOF + hold_mv, (k < d) ? 1 : 0);
            arr_c = a + d * FTOF + hold_mv;
            push(EV_ARR, f, arr_c, model_dir);
            push(EV_DOOR, f, arr_c + DOOR + 1 + hold_door, 1);
            model_floor = f;
        end
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_ready"},  req_ready, 1);
        chk({p, "_floor"},  now_floor, HOME);
        chk({p, "_moving"}, moving, 0);
        chk({p, "_dir_up"}, dir_up, 1);
        chk({p, "_arr"},    arr, 0);
        chk({p, "_door"},   door_open, 0);
        chk({p, "_err"},    req_err, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        #1 rst_n = 1'b1;

        // 1 -> 4 upward, then 4 -> 2 downward
        send_req(4, 0, 0);
        send_req(2, 0, 0);
        @(negedge clk);
        chk("dn_dir", dir_up, 0);
        chk("dn_moving", moving, 1);

        // Same floor: immediate arrival, no travel
        send_req(2, 0, 0);
        @(negedge clk);
        chk("same_moving", moving, 0);
        chk("same_floor", now_floor, 2);

        // Out-of-range requests
        send_req(0, 0, 0);
        send_req(9, 0, 0);
        @(negedge clk);
        chk("err_ready", req_ready, 1);
        chk("err_moving", moving, 0);
        chk("err_floor", now_floor, 2);

        // Asynchronous reset while travelling 2 -> 6, at floor 3
        send_req(6, 0, 0);
        repeat (70) @(negedge clk);
        chk("mid_floor", now_floor, 3);
        chk("mid_moving", moving, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        sb.delete();
        model_floor = HOME;
        model_dir   = 1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        send_req(3, 0, 0);

`ifdef CAR_ESTOP_EN
        // 3 -> 5 with 30-cycle stop mid-floor and 20-cycle stop during door
        send_req(5, 30, 20);
        repeat (10) @(negedge clk);
        estop = 1'b1;
        repeat (15) @(negedge clk);
        chk("estop_moving", moving, 0);
        chk("estop_floor", now_floor, 3);
        repeat (15) @(negedge clk);
        estop = 1'b0;
        n = 0;
        while (!arr && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("estop_arr_seen", arr, 1);
        repeat (5) @(negedge clk);
        estop = 1'b1;
        repeat (20) @(negedge clk);
        chk("estop_door", door_open, 1);
        estop = 1'b0;
`endif

        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
